// File: rtl/agc_linear_ahb_if.sv
// Stream and AHB-Lite signals of the linear AGC block.
// The slave modport is the AGC's view and the master modport is the environment's view.
interface agc_linear_ahb_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] tdata_s;
  logic          tvalid_s;
  logic          tready_s;
  logic [DW-1:0] tdata_m;
  logic          tvalid_m;
  logic          tready_m;
  logic [31:0]   haddr_s;
  logic [2:0]    hburst_s;
  logic [2:0]    hsize_s;
  logic [1:0]    htrans_s;
  logic [31:0]   hwdata_s;
  logic          hwrite_s;
  logic [31:0]   hrdata_s;
  logic          hreadyout_s;
  logic          hresp_s;
  logic          hsel_s;

  modport slave (
    input  tdata_s, tvalid_s, tready_m,
    input  haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    output tready_s, tdata_m, tvalid_m,
    output hrdata_s, hreadyout_s, hresp_s
  );

  modport master (
    output tdata_s, tvalid_s, tready_m,
    output haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    input  tready_s, tdata_m, tvalid_m,
    input  hrdata_s, hreadyout_s, hresp_s
  );
endinterface

// File: rtl/agc_linear_ahb.sv
// Linear AGC: a Q8.8 gain multiply with saturation, a peak-hold envelope with slow decay,
// and a proportional gain loop steering the envelope toward TARGET. The CPU configures
// and monitors the block through a zero-wait-state AHB-Lite register file.
module agc_linear_ahb #(
  parameter int DW = 16,
  parameter int K  = 100
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  agc_linear_ahb_if.slave bus
);
  localparam int PW = DW + 17;  // product width, including the sign of the unsigned gain
  localparam int SW = DW + 9;   // width of err*K
  localparam logic signed [PW-1:0] Y_MAX = PW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] Y_MIN = -Y_MAX - PW'(1);
  localparam logic signed [SW:0]   G_MIN = (SW+1)'(1);
  localparam logic signed [SW:0]   G_MAX = (SW+1)'(65535);

  logic          ctrl_en;
  logic [DW-2:0] target;
  logic [15:0]   gain;
  logic [DW-1:0] env;
  logic          sat;
  logic          wr_pend, rd_pend;
  logic [2:0]    addr_q;
  logic          ahb_acc;
  logic          fire;

  logic signed [PW-1:0] prod, shifted;
  logic signed [DW-1:0] y;
  logic                 sat_hit;
  logic [DW-1:0]        y_abs, env_nxt;
  logic signed [DW:0]   err;
  logic signed [SW-1:0] err_k, gstep;
  logic signed [SW:0]   gsum;
  logic [15:0]          gain_nxt;
  logic [31:0]          rdata;

  // The AHB fields below are not needed: every access is a 32-bit word and bursts are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.hburst_s, bus.hsize_s, bus.haddr_s[31:5], bus.haddr_s[1:0],
                         bus.hwdata_s[31:16]};

  assign bus.hreadyout_s = 1'b1;
  assign bus.hresp_s     = 1'b0;
  assign ahb_acc         = bus.hsel_s & bus.htrans_s[1];
  assign bus.tready_s    = ce & (~bus.tvalid_m | bus.tready_m);
  assign fire            = bus.tvalid_s & bus.tready_s;

  // Datapath: gain, clamp, envelope and gain-loop arithmetic for the current input sample.
  always_comb begin
    prod    = $signed({{17{bus.tdata_s[DW-1]}}, bus.tdata_s}) *
              $signed({{(DW+1){1'b0}}, gain});
    shifted = prod >>> 8;
    sat_hit = 1'b0;
    y       = shifted[DW-1:0];
    if (shifted > Y_MAX) begin
      y       = Y_MAX[DW-1:0];
      sat_hit = 1'b1;
    end else if (shifted < Y_MIN) begin
      y       = Y_MIN[DW-1:0];
      sat_hit = 1'b1;
    end
    // The most negative output has no positive twin, so its magnitude is capped at full scale.
    if (!y[DW-1])
      y_abs = y;
    else if (y == Y_MIN[DW-1:0])
      y_abs = Y_MAX[DW-1:0];
    else
      y_abs = ~y + 1'b1;
    env_nxt = (y_abs > env) ? y_abs : env - (env >> 8);
    err     = $signed({2'b00, target}) - $signed({1'b0, env});
    err_k   = $signed({{8{err[DW]}}, err}) * $signed(SW'(K));
    gstep   = err_k >>> 16;
    gsum    = $signed({{(SW-15){1'b0}}, gain}) + $signed({gstep[SW-1], gstep});
    if (gsum < G_MIN)
      gain_nxt = 16'h0001;
    else if (gsum > G_MAX)
      gain_nxt = 16'hFFFF;
    else
      gain_nxt = gsum[15:0];
  end

  // AHB address phase capture and register file; an AHB write to GAIN beats the loop update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      addr_q  <= 3'd0;
      ctrl_en <= 1'b0;
      target  <= {1'b1, {(DW-2){1'b0}}};
      gain    <= 16'h0100;
      sat     <= 1'b0;
    end else begin
      wr_pend <= ahb_acc & bus.hwrite_s;
      rd_pend <= ahb_acc & ~bus.hwrite_s;
      if (ahb_acc)
        addr_q <= bus.haddr_s[4:2];
      if (wr_pend && addr_q == 3'd0)
        ctrl_en <= bus.hwdata_s[0];
      if (wr_pend && addr_q == 3'd1)
        target <= bus.hwdata_s[DW-2:0];
      if (wr_pend && addr_q == 3'd2)
        gain <= bus.hwdata_s[15:0];
      else if (fire && ctrl_en)
        gain <= gain_nxt;
      // A fresh saturation event is kept even if software clears the flag in the same cycle.
      if (fire && sat_hit)
        sat <= 1'b1;
      else if (wr_pend && addr_q == 3'd4 && bus.hwdata_s[0])
        sat <= 1'b0;
    end
  end

  // Registered output stage and envelope tracker; frozen while ce is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.tdata_m  <= '0;
      bus.tvalid_m <= 1'b0;
      env          <= '0;
    end else if (fire) begin
      bus.tdata_m  <= y;
      bus.tvalid_m <= 1'b1;
      env          <= env_nxt;
    end else if (ce && bus.tready_m) begin
      bus.tvalid_m <= 1'b0;
    end
  end

  // Read mux for the data phase; anything other than a pending read returns zero.
  always_comb begin
    rdata = 32'd0;
    if (rd_pend) begin
      case (addr_q)
        3'd0:    rdata = {31'd0, ctrl_en};
        3'd1:    rdata = 32'(target);
        3'd2:    rdata = {16'd0, gain};
        3'd3:    rdata = 32'(env);
        3'd4:    rdata = {31'd0, sat};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign bus.hrdata_s = rdata;
endmodule

// File: tb/tb_agc_linear_ahb.sv
// Bench for agc_linear_ahb: directed register and vector checks, a sine-driven loop
// convergence run and a randomized back-pressure run scored against an arithmetic model.
module tb_agc_linear_ahb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  int   tests = 0;
  int   errs = 0;

  agc_linear_ahb_if #(.DW(16)) bus ();

  agc_linear_ahb #(.DW(16), .K(100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_gain, m_env, m_target, m_en, m_sat;
  int expq[$];
  int n_in, n_out;
  bit last_acc;
  logic [31:0] hr_cap;

  typedef struct {
    logic [15:0] gain;
    int          x;
    int          y;
    bit          sat;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic longint floordiv(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_gain = 256; m_env = 0; m_target = 16384; m_en = 0; m_sat = 0;
    expq.delete();
  endtask

  function automatic int model_sample(input int x);
    longint q;
    int y, a, err, g;
    q = floordiv(longint'(x) * m_gain, 256);
    if (q > 32767) begin y = 32767; m_sat = 1; end
    else if (q < -32768) begin y = -32768; m_sat = 1; end
    else y = int'(q);
    a = (y < 0) ? ((-y > 32767) ? 32767 : -y) : y;
    err = m_target - m_env;
    m_env = (a > m_env) ? a : m_env - m_env / 256;
    if (m_en != 0) begin
      g = m_gain + int'(floordiv(longint'(err) * 100, 65536));
      m_gain = (g < 1) ? 1 : (g > 65535) ? 65535 : g;
    end
    return y;
  endfunction

  // One clock: check the stream against the model on the falling edge, then cross the rising edge.
  task automatic step();
    bit rst_now, exp_ready;
    @(negedge clk);
    rst_now = !reset_n;
    hr_cap = bus.hrdata_s;
    chk("hreadyout", bus.hreadyout_s, 1);
    chk("hresp", bus.hresp_s, 0);
    last_acc = 1'b0;
    if (!rst_now) begin
      exp_ready = ce && (expq.size() == 0 || bus.tready_m);
      chk("tvalid_m", bus.tvalid_m, expq.size() > 0);
      chk("tready_s", bus.tready_s, exp_ready);
      if (ce && bus.tready_m && expq.size() > 0) begin
        chk("tdata_m", int'($signed(bus.tdata_m)), expq.pop_front());
        n_out++;
      end
      if (bus.tvalid_s && exp_ready) begin
        expq.push_back(model_sample(int'($signed(bus.tdata_s))));
        last_acc = 1'b1;
        n_in++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_now) model_reset();
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1; bus.haddr_s = addr;
    step();
    bus.hsel_s = 1'b0; bus.htrans_s = 2'b00; bus.hwrite_s = 1'b0; bus.hwdata_s = data;
    step();
    case (addr[4:0])
      5'h00: m_en = int'(data[0]);
      5'h04: m_target = int'(data[14:0]);
      5'h08: m_gain = int'(data[15:0]);
      5'h10: if (data[0]) m_sat = 0;
      default: ;
    endcase
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b0; bus.haddr_s = addr;
    step();
    bus.hsel_s = 1'b0; bus.htrans_s = 2'b00;
    step();
    data = hr_cap;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int sine[8];
    int yq;
    sine = '{0, 2828, 4000, 2828, 0, -2828, -4000, -2828};

    vecs[0]  = '{16'h0200,   1000,   2000, 1'b0};
    vecs[1]  = '{16'h0200,  -1000,  -2000, 1'b0};
    vecs[2]  = '{16'h0200,  20000,  32767, 1'b1};
    vecs[3]  = '{16'h0200, -20000, -32768, 1'b1};
    vecs[4]  = '{16'h0100, -32768, -32768, 1'b0};
    vecs[5]  = '{16'h0080,     -1,     -1, 1'b0};
    vecs[6]  = '{16'h0080,      1,      0, 1'b0};
    vecs[7]  = '{16'hFFFF,      1,    255, 1'b0};
    vecs[8]  = '{16'hFFFF,     -1,   -256, 1'b0};
    vecs[9]  = '{16'h0001,  32767,    127, 1'b0};
    vecs[10] = '{16'h0200,  16383,  32766, 1'b0};
    vecs[11] = '{16'h0200,  16384,  32767, 1'b1};
    vecs[12] = '{16'h0200, -16384, -32768, 1'b0};
    vecs[13] = '{16'h0200, -16385, -32768, 1'b1};

    bus.tdata_s = '0; bus.tvalid_s = 1'b0; bus.tready_m = 1'b1;
    bus.haddr_s = '0; bus.hburst_s = '0; bus.hsize_s = 3'b010; bus.htrans_s = '0;
    bus.hwdata_s = '0; bus.hwrite_s = 1'b0; bus.hsel_s = 1'b0;
    n_in = 0; n_out = 0;
    model_reset();
    do_reset();

    // Reset values
    chk("rst tvalid_m", bus.tvalid_m, 0);
    chk("rst tdata_m", bus.tdata_m, 0);
    chk("rst hrdata", bus.hrdata_s, 0);
    ahb_read(32'h00, rd); chk("rst CTRL", rd, 0);
    ahb_read(32'h04, rd); chk("rst TARGET", rd, 32'h4000);
    ahb_read(32'h08, rd); chk("rst GAIN", rd, 32'h0100);
    ahb_read(32'h0C, rd); chk("rst ENV", rd, 0);
    ahb_read(32'h10, rd); chk("rst STATUS", rd, 0);

    // Register access and unmapped space
    ahb_write(32'h08, 32'h1234);
    ahb_read(32'h08, rd); chk("GAIN rw", rd, 32'h1234);
    ahb_write(32'h1C, 32'hFFFF_FFFF);
    ahb_read(32'h1C, rd); chk("unmapped read", rd, 0);
    ahb_read(32'h00, rd); chk("CTRL after unmapped", rd, 0);
    ahb_read(32'h04, rd); chk("TARGET after unmapped", rd, 32'h4000);
    ahb_read(32'h08, rd); chk("GAIN after unmapped", rd, 32'h1234);

    // Table-driven gain/saturation vectors, EN=0
    foreach (vecs[i]) begin
      ahb_write(32'h08, {16'd0, vecs[i].gain});
      bus.tdata_s = vecs[i].x[15:0]; bus.tvalid_s = 1'b1; bus.tready_m = 1'b1;
      step();
      bus.tvalid_s = 1'b0;
      chk($sformatf("vec%0d valid", i), bus.tvalid_m, 1);
      chk($sformatf("vec%0d y", i), int'($signed(bus.tdata_m)), vecs[i].y);
      step();
      ahb_read(32'h10, rd);
      chk($sformatf("vec%0d sat", i), rd, vecs[i].sat);
      ahb_write(32'h10, 32'h1);
      ahb_read(32'h10, rd);
      chk($sformatf("vec%0d sat clr", i), rd, 0);
    end
    ahb_read(32'h0C, rd); chk("ENV after vectors", rd, m_env);

    // Output held under back-pressure, then ce low freezes the stage
    ahb_write(32'h08, 32'h0200);
    bus.tready_m = 1'b0; bus.tdata_s = 16'd300; bus.tvalid_s = 1'b1;
    step();
    bus.tdata_s = 16'd7;
    step(); step();
    chk("hold data", int'($signed(bus.tdata_m)), 600);
    ce = 1'b0; bus.tready_m = 1'b1;
    step(); step();
    chk("ce0 hold valid", bus.tvalid_m, 1);
    ce = 1'b1;
    step();
    bus.tvalid_s = 1'b0;
    step(); step();

    // Loop convergence with a sine of amplitude 4000
    do_reset();
    ahb_write(32'h00, 32'h1);
    bus.tready_m = 1'b1; bus.tvalid_s = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      bus.tdata_s = sine[n % 8][15:0];
      step();
    end
    bus.tvalid_s = 1'b0;
    step();
    ahb_read(32'h08, rd);
    chk("sine GAIN model", rd, m_gain);
    chk("sine GAIN near 0x400", (rd >= 32'h3A0 && rd <= 32'h460), 1);
    ahb_read(32'h0C, rd);
    chk("sine ENV model", rd, m_env);
    chk("sine ENV within 5pct", (rd >= 32'd15565 && rd <= 32'd17203), 1);

    // Randomized back-pressure and clock-enable run
    ahb_write(32'h04, 32'h3000);
    ahb_write(32'h08, 32'h0180);
    n_in = 0; n_out = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!bus.tvalid_s || last_acc) begin
        bus.tvalid_s = ($urandom_range(0, 3) != 0);
        yq = int'($urandom_range(0, 65535)) - 32768;
        bus.tdata_s = yq[15:0];
      end
      bus.tready_m = ($urandom_range(0, 2) != 0);
      ce = ($urandom_range(0, 7) != 0);
      step();
    end
    bus.tvalid_s = 1'b0; bus.tready_m = 1'b1; ce = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("random in==out", n_out, n_in);
    chk("random queue empty", expq.size(), 0);
    ahb_read(32'h08, rd); chk("random GAIN", rd, m_gain);
    ahb_read(32'h0C, rd); chk("random ENV", rd, m_env);
    ahb_read(32'h10, rd); chk("random STATUS", rd, m_sat);

    // Reset with a sample in flight drops it
    bus.tready_m = 1'b0; bus.tdata_s = 16'd100; bus.tvalid_s = 1'b1;
    step();
    bus.tvalid_s = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid reset tvalid_m", bus.tvalid_m, 0);
    chk("mid reset tdata_m", bus.tdata_m, 0);
    ahb_read(32'h08, rd); chk("mid reset GAIN", rd, 32'h0100);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
